traffic_light_ctrl: RTL and testbench

- Two-road intersection sequencer: drives the red/yellow/green lamps for road A and road B.
- Produces per-road seconds-remaining countdowns (7-bit binary, 0..99) that feed the binary-to-BCD converters and 7-segment path.
- Derives a 1 s tick from the system clock and steps a 6-phase state machine.

---
 rtl/traffic_light_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer: 1 s prescaler, 6-phase lamp FSM and per-road countdowns.
// Optional night-flash mode is compiled in with `define NIGHT_FLASH_EN.
module traffic_light_ctrl #(
    parameter int CLK_DIV  = 50000000,
    parameter int T_GREEN  = 25,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       NIGHT,
    output logic [2:0] LIGHT_A,
    output logic [2:0] LIGHT_B,
    output logic [6:0] CNT_A,
    output logic [6:0] CNT_B,
    output logic       TICK
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [6:0] D_G  = 7'(T_GREEN);
    localparam logic [6:0] D_Y  = 7'(T_YELLOW);
    localparam logic [6:0] D_AR = 7'(T_ALLRED);
    localparam logic [8:0] E_G  = 9'(T_GREEN);
    localparam logic [8:0] E_Y  = 9'(T_YELLOW);
    localparam logic [8:0] E_AR = 9'(T_ALLRED);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
`ifdef NIGHT_FLASH_EN
        , S_NF = 3'd6
`endif
    } state_t;

    function automatic logic [6:0] sat99(input logic [8:0] v);
        if (v > 9'd99) begin
            sat99 = 7'd99;
        end else begin
            sat99 = v[6:0];
        end
    endfunction

    logic [PW-1:0] r_presc;
    state_t        r_state;
    logic [6:0]    r_pc;

    logic [PW-1:0] w_presc_nx;
    logic          w_tick_nx;
    logic          w_step;
    state_t        w_state_nx;
    logic [6:0]    w_pc_nx;
    state_t        w_seq_state;
    logic [6:0]    w_seq_pc;
    logic [2:0]    w_la;
    logic [2:0]    w_lb;
    logic [8:0]    w_sum_a;
    logic [8:0]    w_sum_b;
    logic [8:0]    w_pc9;

`ifdef NIGHT_FLASH_EN
    logic          r_flash;
    logic          w_flash_nx;
`else
    logic          w_unused_night;
    assign w_unused_night = NIGHT;
`endif

    assign w_step = EN && (r_presc == PRE_MAX);

    // Normal phase sequence: decrement, or advance and load the next duration at pc==1.
    always_comb begin
        w_seq_state = r_state;
        w_seq_pc    = r_pc;
        if (w_step) begin
            if (r_pc > 7'd1) begin
                w_seq_pc = r_pc - 7'd1;
            end else begin
                case (r_state)
                    S0:      begin w_seq_state = S1; w_seq_pc = D_Y;  end
                    S1:      begin w_seq_state = S2; w_seq_pc = D_AR; end
                    S2:      begin w_seq_state = S3; w_seq_pc = D_G;  end
                    S3:      begin w_seq_state = S4; w_seq_pc = D_Y;  end
                    S4:      begin w_seq_state = S5; w_seq_pc = D_AR; end
                    default: begin w_seq_state = S0; w_seq_pc = D_G;  end
                endcase
            end
        end else begin
            w_seq_state = r_state;
            w_seq_pc    = r_pc;
        end
    end

    // Next-state selection: prescaler, tick and night override; EN low holds everything.
    always_comb begin
        w_presc_nx = r_presc;
        w_tick_nx  = 1'b0;
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
`ifdef NIGHT_FLASH_EN
        w_flash_nx = r_flash;
`endif
        if (EN) begin
            if (r_presc == PRE_MAX) begin
                w_presc_nx = {PW{1'b0}};
            end else begin
                w_presc_nx = r_presc + PW'(1);
            end
            w_tick_nx = (w_presc_nx == PRE_MAX);
`ifdef NIGHT_FLASH_EN
            if (NIGHT) begin
                w_state_nx = S_NF;
                if (r_state != S_NF) begin
                    w_flash_nx = 1'b1;
                end else if (w_step) begin
                    w_flash_nx = ~r_flash;
                end else begin
                    w_flash_nx = r_flash;
                end
            end else if (r_state == S_NF) begin
                w_state_nx = S5;
                w_pc_nx    = D_AR;
            end else begin
                w_state_nx = w_seq_state;
                w_pc_nx    = w_seq_pc;
            end
`else
            w_state_nx = w_seq_state;
            w_pc_nx    = w_seq_pc;
`endif
        end else begin
            w_presc_nx = r_presc;
            w_tick_nx  = 1'b0;
        end
    end

    // Lamp and countdown decode of the next state; a red road counts down to its next green.
    always_comb begin
        w_la    = 3'b100;
        w_lb    = 3'b100;
        w_pc9   = {2'b00, w_pc_nx};
        w_sum_a = w_pc9;
        w_sum_b = w_pc9;
        case (w_state_nx)
            S0: begin w_la = 3'b001; w_sum_b = w_pc9 + E_Y + E_AR; end
            S1: begin w_la = 3'b010; w_sum_b = w_pc9 + E_AR; end
            S2: begin w_sum_a = w_pc9 + E_G + E_Y + E_AR; end
            S3: begin w_lb = 3'b001; w_sum_a = w_pc9 + E_Y + E_AR; end
            S4: begin w_lb = 3'b010; w_sum_a = w_pc9 + E_AR; end
            S5: begin w_sum_b = w_pc9 + E_G + E_Y + E_AR; end
`ifdef NIGHT_FLASH_EN
            S_NF: begin
                w_la    = {1'b0, w_flash_nx, 1'b0};
                w_lb    = {1'b0, w_flash_nx, 1'b0};
                w_sum_a = 9'd0;
                w_sum_b = 9'd0;
            end
`endif
            default: begin w_la = 3'b100; w_lb = 3'b100; end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_presc <= {PW{1'b0}};
            r_state <= S0;
            r_pc    <= D_G;
            TICK    <= 1'b0;
            LIGHT_A <= 3'b001;
            LIGHT_B <= 3'b100;
            CNT_A   <= sat99(E_G);
            CNT_B   <= sat99(E_G + E_Y + E_AR);
`ifdef NIGHT_FLASH_EN
            r_flash <= 1'b0;
`endif
        end else begin
            r_presc <= w_presc_nx;
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            TICK    <= w_tick_nx;
            LIGHT_A <= w_la;
            LIGHT_B <= w_lb;
            CNT_A   <= sat99(w_sum_a);
            CNT_B   <= sat99(w_sum_b);
`ifdef NIGHT_FLASH_EN
            r_flash <= w_flash_nx;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: vector table for the main sequence plus
// hand sequences for reset, saturation and (with NIGHT_FLASH_EN) night flash.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       night;
    logic [2:0] la, lb, sla, slb;
    logic [6:0] ca, cb, sca, scb;
    logic       tick, stick;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl #(.CLK_DIV(4), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1)) u_dut (
        .CLK(clk), .RST_N(rst_n), .EN(en), .NIGHT(night),
        .LIGHT_A(la), .LIGHT_B(lb), .CNT_A(ca), .CNT_B(cb), .TICK(tick)
    );

    traffic_light_ctrl #(.CLK_DIV(2), .T_GREEN(60), .T_YELLOW(30), .T_ALLRED(20)) u_sat (
        .CLK(clk), .RST_N(rst_n), .EN(en), .NIGHT(night),
        .LIGHT_A(sla), .LIGHT_B(slb), .CNT_A(sca), .CNT_B(scb), .TICK(stick)
    );

    typedef struct {
        int         ncyc;
        logic       en;
        logic       night;
        logic [2:0] la;
        logic [2:0] lb;
        logic [6:0] ca;
        logic [6:0] cb;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic [2:0] ela, input logic [2:0] elb,
                              input logic [6:0] eca, input logic [6:0] ecb, input logic etick);
        cmp({tag, ".LIGHT_A"}, {6'd0, la}, {6'd0, ela});
        cmp({tag, ".LIGHT_B"}, {6'd0, lb}, {6'd0, elb});
        cmp({tag, ".CNT_A"}, {2'd0, ca}, {2'd0, eca});
        cmp({tag, ".CNT_B"}, {2'd0, cb}, {2'd0, ecb});
        cmp({tag, ".TICK"}, {8'd0, tick}, {8'd0, etick});
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        night = 1'b0;
        step(3);
        check_main("reset", 3'b001, 3'b100, 7'd5, 7'd8, 1'b0);
        rst_n = 1'b1;

        // Edge count c after release: prescaler = c mod 4, tick k lands on edge 4k.
        vecs.push_back('{3,  1'b1, 1'b0, 3'b001, 3'b100, 7'd5, 7'd8, 1'b1}); // c=3 tick pulse
        vecs.push_back('{1,  1'b1, 1'b0, 3'b001, 3'b100, 7'd4, 7'd7, 1'b0}); // c=4
        vecs.push_back('{16, 1'b1, 1'b0, 3'b010, 3'b100, 7'd2, 7'd3, 1'b0}); // c=20 S1
        vecs.push_back('{8,  1'b1, 1'b0, 3'b100, 3'b100, 7'd9, 7'd1, 1'b0}); // c=28 S2
        vecs.push_back('{4,  1'b1, 1'b0, 3'b100, 3'b001, 7'd8, 7'd5, 1'b0}); // c=32 S3 entry
        vecs.push_back('{3,  1'b1, 1'b0, 3'b100, 3'b001, 7'd8, 7'd5, 1'b1}); // c=35
        vecs.push_back('{1,  1'b1, 1'b0, 3'b100, 3'b001, 7'd7, 7'd4, 1'b0}); // c=36
        vecs.push_back('{16, 1'b1, 1'b0, 3'b100, 3'b010, 7'd3, 7'd2, 1'b0}); // c=52 S4
        vecs.push_back('{8,  1'b1, 1'b0, 3'b100, 3'b100, 7'd1, 7'd9, 1'b0}); // c=60 S5
        vecs.push_back('{4,  1'b1, 1'b0, 3'b001, 3'b100, 7'd5, 7'd8, 1'b0}); // c=64 back to S0
        vecs.push_back('{9,  1'b1, 1'b0, 3'b001, 3'b100, 7'd3, 7'd6, 1'b0}); // c=73 presc=1
        vecs.push_back('{5,  1'b0, 1'b0, 3'b001, 3'b100, 7'd3, 7'd6, 1'b0}); // frozen
        vecs.push_back('{5,  1'b0, 1'b0, 3'b001, 3'b100, 7'd3, 7'd6, 1'b0}); // still frozen
        vecs.push_back('{1,  1'b1, 1'b0, 3'b001, 3'b100, 7'd3, 7'd6, 1'b0}); // presc=2
        vecs.push_back('{1,  1'b1, 1'b0, 3'b001, 3'b100, 7'd3, 7'd6, 1'b1}); // presc=3
        vecs.push_back('{1,  1'b1, 1'b0, 3'b001, 3'b100, 7'd2, 7'd5, 1'b0}); // resumed tick
`ifndef NIGHT_FLASH_EN
        vecs.push_back('{4,  1'b1, 1'b1, 3'b001, 3'b100, 7'd1, 7'd4, 1'b0}); // NIGHT ignored
`endif

        foreach (vecs[i]) begin
            en    = vecs[i].en;
            night = vecs[i].night;
            step(vecs[i].ncyc);
            check_main($sformatf("vec%0d", i), vecs[i].la, vecs[i].lb, vecs[i].ca,
                       vecs[i].cb, vecs[i].tick);
        end

        // Mid-phase reset with EN and NIGHT high; reset must win.
        en    = 1'b1;
        night = 1'b1;
        rst_n = 1'b0;
        step(2);
        check_main("midreset", 3'b001, 3'b100, 7'd5, 7'd8, 1'b0);
        cmp("sat.reset.CNT_A", {2'd0, sca}, 9'd60);
        cmp("sat.reset.CNT_B", {2'd0, scb}, 9'd99);
        cmp("sat.reset.LIGHT_A", {6'd0, sla}, 9'd1);
        night = 1'b0;
        rst_n = 1'b1;

        // Saturated instance ticks every 2 edges; CNT_B = min(99, 110 - ticks).
        step(22);
        cmp("sat.t11.CNT_A", {2'd0, sca}, 9'd49);
        cmp("sat.t11.CNT_B", {2'd0, scb}, 9'd99);
        step(2);
        cmp("sat.t12.CNT_A", {2'd0, sca}, 9'd48);
        cmp("sat.t12.CNT_B", {2'd0, scb}, 9'd98);
        check_main("c24", 3'b010, 3'b100, 7'd1, 7'd2, 1'b0);

`ifdef NIGHT_FLASH_EN
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(32);
        check_main("nf.s3", 3'b100, 3'b001, 7'd8, 7'd5, 1'b0);
        night = 1'b1;
        step(1);
        check_main("nf.entry", 3'b010, 3'b010, 7'd0, 7'd0, 1'b0);
        step(3);
        check_main("nf.flash0", 3'b000, 3'b000, 7'd0, 7'd0, 1'b0);
        step(4);
        check_main("nf.flash1", 3'b010, 3'b010, 7'd0, 7'd0, 1'b0);
        night = 1'b0;
        step(1);
        check_main("nf.exit", 3'b100, 3'b100, 7'd1, 7'd9, 1'b0);
        step(3);
        check_main("nf.s0", 3'b001, 3'b100, 7'd5, 7'd8, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
